// File: rtl/ldtu_mode_sequencer.sv
// Operating-mode sequencer: synchronizes calibration/test requests and walks the
// datapath through reset, warm-up, run and drain phases with registered outputs.
module ldtu_mode_sequencer #(
  parameter int WARMUP_CYCLES = 16,
  parameter int DRAIN_MAX     = 64,
  parameter int CNT_W         = 7
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CALIBRATION_BUSY,
  input  logic       TEST_ENABLE,
  input  logic       fifo_empty,
  output logic       dtu_rst_b,
  output logic [1:0] out_sel,
  output logic [2:0] mode,
  output logic       drain_timeout
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_CALIB  = 3'd1,
    S_TEST   = 3'd2,
    S_WARMUP = 3'd3,
    S_RUN    = 3'd4,
    S_DRAIN  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'(WARMUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_MAX - 1);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic             cal_meta, cal_s;
  logic             tst_meta, tst_s;
  logic             drain_limit;

  assign drain_limit = (cnt == DRAIN_LAST);
  assign mode        = state;

  // Output encoding per state; applied to the next state so outputs stay registered.
  function automatic logic [1:0] sel_of(input state_t s);
    case (s)
      S_TEST:          sel_of = 2'd2;
      S_RUN, S_DRAIN:  sel_of = 2'd1;
      default:         sel_of = 2'd0;
    endcase
  endfunction

  always_comb begin
    state_next = state;
    case (state)
      S_RESET:
        state_next = cal_s ? S_CALIB : (tst_s ? S_TEST : S_WARMUP);
      S_CALIB:
        if (!cal_s) state_next = tst_s ? S_TEST : S_WARMUP;
      S_TEST:
        if (cal_s)       state_next = S_CALIB;
        else if (!tst_s) state_next = S_WARMUP;
      S_WARMUP:
        // Nothing queued yet, so requests preempt warm-up without draining.
        if (cal_s)                  state_next = S_CALIB;
        else if (tst_s)             state_next = S_TEST;
        else if (cnt == WARM_LAST)  state_next = S_RUN;
      S_RUN:
        if (cal_s || tst_s) state_next = S_DRAIN;
      S_DRAIN:
        if (fifo_empty || drain_limit)
          state_next = cal_s ? S_CALIB : (tst_s ? S_TEST : S_RUN);
      default:
        state_next = S_RESET;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cal_meta      <= 1'b0;
      cal_s         <= 1'b0;
      tst_meta      <= 1'b0;
      tst_s         <= 1'b0;
      state         <= S_RESET;
      cnt           <= '0;
      dtu_rst_b     <= 1'b0;
      out_sel       <= 2'd0;
      drain_timeout <= 1'b0;
    end else begin
      cal_meta <= CALIBRATION_BUSY;
      cal_s    <= cal_meta;
      tst_meta <= TEST_ENABLE;
      tst_s    <= tst_meta;
      state    <= state_next;

      if (state_next != state)
        cnt <= '0;
      else if (state == S_WARMUP || state == S_DRAIN)
        cnt <= cnt + 1'b1;

      dtu_rst_b <= !(state_next == S_RESET || state_next == S_CALIB || state_next == S_TEST);
      out_sel   <= sel_of(state_next);

      // A simultaneous empty FIFO counts as a clean drain.
      if (state == S_DRAIN && drain_limit && !fifo_empty)
        drain_timeout <= 1'b1;
    end
  end

endmodule

// File: doc/ldtu_mode_sequencer.md
# ldtu_mode_sequencer

Operating-mode sequencer for the LiTE-DTU 160 MHz core. It turns the asynchronous RST, CALIBRATION_BUSY and TEST_ENABLE controls into a clean, registered sequence of datapath reset, warm-up, run and drain phases. It drives the datapath reset and the output-word mux select, so a calibration or test request never truncates words already queued in the output FIFO.

## Interface
- WARMUP_CYCLES, 16: cycles the datapath runs out of reset, with the idle pattern on the link, before DTU data is selected.
- DRAIN_MAX, 64: maximum cycles spent waiting for the output FIFO to empty before a mode change is forced.
- CNT_W, 7: phase counter width; must satisfy 2^CNT_W > max(WARMUP_CYCLES, DRAIN_MAX).
- CLK  in  1  160 MHz system clock.
- RST  in  1  asynchronous, active-high reset.
- CALIBRATION_BUSY  in  1  ADC calibration request, asynchronous to CLK (OR of both gains upstream).
- TEST_ENABLE  in  1  ATU test-mode request, asynchronous to CLK.
- fifo_empty  in  1  output FIFO empty flag, synchronous to CLK.
- dtu_rst_b  out  1  datapath reset, active-low: 0 holds BS/iFIFO/Encoder/CU/oFIFO in reset.
- out_sel  out  2  output mux select: 0 = idle pattern, 1 = DTU FIFO, 2 = ATU words; 3 is never driven.
- mode  out  3  current state code, for status readback.
- drain_timeout  out  1  sticky flag: a drain ended by timeout with the FIFO not empty.

## Operation
- CALIBRATION_BUSY and TEST_ENABLE each pass through a 2-FF synchronizer (reset to 0), giving cal_s and tst_s. All decisions use the synchronized versions. cal_s has priority over tst_s.
- States and codes: RESET=0, CALIB=1, TEST=2, WARMUP=3, RUN=4, DRAIN=5.
- State outputs (dtu_rst_b / out_sel):
  - RESET, CALIB: 0 / 0.
  - TEST: 0 / 2.
  - WARMUP: 1 / 0.
  - RUN, DRAIN: 1 / 1.
- Transitions from each state:
  - RESET: next cycle go to CALIB if cal_s, else TEST if tst_s, else WARMUP.
  - CALIB: stay while cal_s. On release go to TEST if tst_s, else WARMUP.
  - TEST: go to CALIB if cal_s. Go to WARMUP if tst_s is 0. Otherwise stay.
  - WARMUP: go to CALIB or TEST immediately if requested; nothing is queued, so no drain is needed. Otherwise count up; when cnt == WARMUP_CYCLES-1, go to RUN.
  - RUN: go to DRAIN on cal_s or tst_s.
  - DRAIN: count up each cycle. Exit when fifo_empty, or when cnt == DRAIN_MAX-1. Exit target is CALIB if cal_s, else TEST if tst_s, else RUN (request withdrawn).
- cnt clears on every state entry.
- drain_timeout sets when DRAIN exits on the count with fifo_empty at 0. It clears only on RST. If fifo_empty and the count limit occur in the same cycle, the flag does not set.
- Asserting RST in any state forces RESET and all output reset values asynchronously. Pending drains are abandoned.

## Timing
- Reset values: dtu_rst_b=0, out_sel=0, mode=0, drain_timeout=0, cnt=0, synchronizers=0.
- All outputs are registered Moore outputs and change only on a CLK rising edge after RST deassertion.
- Request latency: an input edge affects the state register on the 3rd CLK edge after it is sampled (2 synchronizer edges plus 1 state edge).
- WARMUP lasts exactly WARMUP_CYCLES cycles. out_sel goes to 1 on the following edge.
- DRAIN lasts 1 to DRAIN_MAX cycles. If fifo_empty is 1 on the first DRAIN cycle, the exit happens at the next edge.
- A request pulse shorter than one CLK period may be missed. Upstream must hold requests for at least 2 CLK cycles.

## Test plan
- RST released with both requests at 0: RESET for 1 cycle, then WARMUP for 16 cycles with dtu_rst_b=1 and out_sel=0, then RUN with out_sel=1.
- In RUN, raise CALIBRATION_BUSY with fifo_empty=0, then assert fifo_empty 10 cycles later: DRAIN for 10 cycles, then CALIB with dtu_rst_b=0 and drain_timeout=0.
- In RUN, raise TEST_ENABLE and hold fifo_empty=0: DRAIN for exactly 64 cycles, then TEST with out_sel=2 and drain_timeout=1; the flag stays set until RST.
- CALIBRATION_BUSY and TEST_ENABLE raised on the same cycle from WARMUP: go directly to CALIB. Drop CALIBRATION_BUSY: go to TEST. Drop TEST_ENABLE: WARMUP for 16 cycles, then RUN.
- In DRAIN, withdraw the request before fifo_empty rises: return to RUN and keep out_sel=1.
- Assert RST mid-DRAIN: outputs go to reset values asynchronously, before the next CLK edge.
